// File: rtl/iob_bus_arb2.sv
// Round-robin 2:1 IOb arbiter with 1-cycle arbitration; ownership held while reads are outstanding.
// Requests forwarded combinationally in OWN states; stalls at MAX_OUTST outstanding reads.
module iob_bus_arb2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                owner,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          served, served_nxt;
  logic          last, last_nxt;
  logic          own, own_nxt;
  logic          err_q, err_nxt;
  logic          sel, room, cur_valid, oth_valid, accept, rd_accept, rsp;

  always_comb begin
    sel       = (state == OWN1);
    room      = (cnt < MAX_C);
    cur_valid = sel ? m1_valid : m0_valid;
    oth_valid = sel ? m0_valid : m1_valid;
    s_valid   = (state != IDLE) & cur_valid & room;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    if (state == OWN0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (state == OWN1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
    m0_ready  = (state == OWN0) & s_ready & room;
    m1_ready  = (state == OWN1) & s_ready & room;
    accept    = s_valid & s_ready;
    rd_accept = accept & (s_wstrb == '0);
    // A response with nothing outstanding is dropped, never routed
    rsp       = s_rvalid & (cnt != '0);
    m0_rvalid = rsp & (state == OWN0);
    m1_rvalid = rsp & (state == OWN1);
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign owner    = own;
  assign busy     = (state != IDLE);
  assign err      = err_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    served_nxt = served | accept;
    last_nxt   = last;
    own_nxt    = own;
    err_nxt    = err_q | (s_rvalid & (cnt == '0));
    if (rd_accept && !rsp) cnt_nxt = cnt + 1'b1;
    else if (rsp && !rd_accept) cnt_nxt = cnt - 1'b1;
    case (state)
      IDLE: begin
        if (m0_valid && (!m1_valid || last)) begin
          state_nxt = OWN0;
          own_nxt   = 1'b0;
        end else if (m1_valid) begin
          state_nxt = OWN1;
          own_nxt   = 1'b1;
        end
      end
      OWN0, OWN1: begin
        // Counting this cycle's accept as service lets a waiting master in right after a write
        if (cnt_nxt == '0 && (!cur_valid || (served_nxt && oth_valid))) begin
          state_nxt  = IDLE;
          last_nxt   = sel;
          served_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      served <= 1'b0;
      last   <= 1'b1;
      own    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      served <= served_nxt;
      last   <= last_nxt;
      own    <= own_nxt;
      err_q  <= err_nxt;
    end
  end
endmodule

// File: tb/tb_iob_bus_arb2.sv
// Scoreboard bench for iob_bus_arb2: directed master requests, delayed-response slave model.
module tb_iob_bus_arb2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready, s_rvalid = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata = '0;
  logic [3:0]  s_wstrb;
  logic        owner, busy, err;

  iob_bus_arb2 #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [3:0] s; logic [31:0] d;} req_t;
  typedef struct {logic o; logic [31:0] a; logic [3:0] s; logic [31:0] d;} acc_t;
  typedef struct {logic m; logic [31:0] d;} rsp_t;
  typedef struct {logic [31:0] d; int due;} pend_t;

  req_t  m0_q[$], m1_q[$];
  acc_t  exp_acc[$];
  rsp_t  exp_rsp[$];
  pend_t pend[$];
  int    vectors = 0, miscompares = 0;
  int    cyc = 0, rsp_dly = 2;
  logic  acc0 = 1'b0, acc1 = 1'b0, inject = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_idle();
    return m0_q.size() == 0 && m1_q.size() == 0 && !m0_valid && !m1_valid && !busy &&
           exp_acc.size() == 0 && exp_rsp.size() == 0 && pend.size() == 0 && !s_rvalid;
  endfunction

  task automatic req(input bit m, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit want_rsp, input logic [31:0] rd);
    req_t r;
    acc_t e;
    rsp_t x;
    r.a = a; r.s = s; r.d = d;
    e.o = m; e.a = a; e.s = s; e.d = d;
    x.m = m; x.d = rd;
    if (m) m1_q.push_back(r);
    else m0_q.push_back(r);
    exp_acc.push_back(e);
    if (want_rsp) exp_rsp.push_back(x);
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while (!is_idle() && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!is_idle()) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: not idle after %0d cycles", nm, maxc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Master drivers: hold each request until the cycle it is accepted
  always begin
    req_t tmp;
    @(posedge clk); #1;
    if (acc0 && m0_q.size() > 0) tmp = m0_q.pop_front();
    if (acc1 && m1_q.size() > 0) tmp = m1_q.pop_front();
    if (m0_q.size() > 0) begin
      m0_valid = 1'b1; m0_addr = m0_q[0].a; m0_wstrb = m0_q[0].s; m0_wdata = m0_q[0].d;
    end else begin
      m0_valid = 1'b0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
    end
    if (m1_q.size() > 0) begin
      m1_valid = 1'b1; m1_addr = m1_q[0].a; m1_wstrb = m1_q[0].s; m1_wdata = m1_q[0].d;
    end else begin
      m1_valid = 1'b0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
    end
  end

  // Slave: in-order responses rsp_dly cycles after the accept, rdata = addr ^ 0xDEADBFEF
  always begin
    pend_t p;
    @(posedge clk); #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      s_rvalid = 1'b1;
      s_rdata  = p.d;
    end else if (inject) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'hBAD0BAD0;
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = '0;
    end
  end

  // Monitor: scoreboard pops on every accept and every routed response
  always begin
    acc_t  e;
    rsp_t  r;
    pend_t p;
    @(negedge clk);
    acc0 = m0_valid & m0_ready;
    acc1 = m1_valid & m1_ready;
    if (s_valid && s_ready) begin
      if (exp_acc.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL acc_unexpected: got accept addr %0h expected none", s_addr);
      end else begin
        e = exp_acc.pop_front();
        chk("acc_owner", 64'(owner), 64'(e.o));
        chk("acc_addr", 64'(s_addr), 64'(e.a));
        chk("acc_wstrb", 64'(s_wstrb), 64'(e.s));
        chk("acc_wdata", 64'(s_wdata), 64'(e.d));
      end
      if (s_wstrb == 4'h0) begin
        p.d = s_addr ^ 32'hDEADBFEF;
        p.due = cyc + rsp_dly;
        pend.push_back(p);
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      chk("rv_excl", 64'(m0_rvalid & m1_rvalid), 64'd0);
      if (exp_rsp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rv_unexpected: got rvalid m0=%0b m1=%0b expected none", m0_rvalid, m1_rvalid);
      end else begin
        r = exp_rsp.pop_front();
        chk("rv_master", 64'(m1_rvalid), 64'(r.m));
        chk("rv_data", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(r.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall, busyc, n;
    rst_n = 1'b0;
    s_ready = 1'b1;
    #3;
    chk("rst_ctl", 64'({s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, owner, busy, err}), 64'd0);
    chk("rst_bus", 64'({s_addr, s_wstrb}), 64'd0);
    chk("rst_wdata", 64'(s_wdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single m0 read: one arbitration cycle, then forwarded
    @(negedge clk);
    req(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("arb_cycle", 64'({s_valid, m0_ready, busy}), 64'd0);
    @(negedge clk);
    chk("grant0", 64'({s_valid, m0_ready, m1_ready, busy, owner}), 64'b11010);
    wait_idle("t1_idle", 50);
    chk("t1_release", 64'({busy, owner}), 64'd0);

    // Simultaneous reads after reset: m0 first; then writes alternate
    do_reset();
    req(1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 32'hDEADBDEF);
    req(1'b1, 32'h300, 4'h0, 32'h0, 1'b1, 32'hDEADBCEF);
    wait_idle("t2_rd_idle", 50);
    req(1'b0, 32'h210, 4'hF, 32'hA0A00001, 1'b0, 32'h0);
    req(1'b1, 32'h310, 4'h3, 32'hB0B00001, 1'b0, 32'h0);
    req(1'b0, 32'h214, 4'hF, 32'hA0A00002, 1'b0, 32'h0);
    req(1'b1, 32'h314, 4'hC, 32'hB0B00002, 1'b0, 32'h0);
    wait_idle("t2_wr_idle", 50);
    chk("t2_owner", 64'(owner), 64'd1);

    // Five back-to-back m1 reads against a 4-deep outstanding limit
    rsp_dly = 8;
    req(1'b1, 32'h400, 4'h0, 32'h0, 1'b1, 32'hDEADBBEF);
    req(1'b1, 32'h404, 4'h0, 32'h0, 1'b1, 32'hDEADBBEB);
    req(1'b1, 32'h408, 4'h0, 32'h0, 1'b1, 32'hDEADBBE7);
    req(1'b1, 32'h40C, 4'h0, 32'h0, 1'b1, 32'hDEADBBE3);
    req(1'b1, 32'h410, 4'h0, 32'h0, 1'b1, 32'hDEADBBFF);
    stall = 0;
    busyc = 0;
    n = 0;
    while (!is_idle() && n < 100) begin
      @(negedge clk);
      n++;
      if (busy && m1_valid && !s_valid) stall++;
      if (busy) busyc++;
    end
    chk("t3_done", 64'(is_idle()), 64'd1);
    chk("t3_stall", 64'(stall), 64'd5);
    chk("t3_busy", 64'(busyc), 64'd18);

    // m0 write while m1 waits: release right after the write accept
    rsp_dly = 2;
    req(1'b0, 32'h500, 4'hF, 32'h12345678, 1'b0, 32'h0);
    req(1'b1, 32'h600, 4'h0, 32'h0, 1'b1, 32'hDEADB9EF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_valid && s_ready && s_wstrb == 4'hF) && n < 20);
    chk("t4_wr_seen", 64'(n < 20), 64'd1);
    @(negedge clk);
    chk("t4_release", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t4_own1", 64'({busy, owner}), 64'b11);
    wait_idle("t4_idle", 50);

    // Stray response with nothing outstanding
    chk("t5_err0", 64'(err), 64'd0);
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("t5_inj", 64'(s_rvalid), 64'd1);
    chk("t5_no_rv", 64'({m0_rvalid, m1_rvalid}), 64'd0);
    @(negedge clk);
    chk("t5_err1", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    chk("t5_sticky", 64'(err), 64'd1);

    // Reset with two m1 reads outstanding; m0 wrote last so only reset restores tie to m0
    req(1'b0, 32'h6F0, 4'h1, 32'h55, 1'b0, 32'h0);
    wait_idle("t6_pre", 50);
    rsp_dly = 20;
    req(1'b1, 32'h700, 4'h0, 32'h0, 1'b0, 32'h0);
    req(1'b1, 32'h704, 4'h0, 32'h0, 1'b0, 32'h0);
    n = 0;
    while (pend.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_outst", 64'(pend.size()), 64'd2);
    chk("t6_busy", 64'({busy, owner}), 64'b11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", 64'({s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, owner, busy, err}), 64'd0);
    chk("t6_rst_bus", 64'({s_addr, s_wstrb}), 64'd0);
    pend.delete();
    exp_rsp.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_dly = 2;
    req(1'b0, 32'h800, 4'h0, 32'h0, 1'b1, 32'hDEADB7EF);
    req(1'b1, 32'h900, 4'h0, 32'h0, 1'b1, 32'hDEADB6EF);
    wait_idle("t6_idle", 60);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_owner", 64'(owner), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iob_bus_arb2.md
Name: iob_bus_arb2

Overview:
- Two-master, one-slave arbiter for the IOb native bus.
- Shares a single memory port between the CPU instruction bus (master 0) and data bus (master 1) when the SoC has only one shared memory or external memory port.
- Grants ownership round-robin and holds it while read responses are outstanding, so rvalid/rdata always route to the master that issued the read.
- Tracks outstanding reads and flags protocol errors.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_OUTST, 4, maximum accepted-but-unanswered reads per ownership period; must be ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_valid  in  1  master 0 request valid.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; all zero means read.
- m0_ready  out  1  master 0 request accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rvalid, m1_rdata  same as m0 for master 1.
- s_valid  out  1  slave request valid.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  DATA_W/8  slave strobes.
- s_ready  in  1  slave accepted request.
- s_rvalid  in  1  slave read data valid.
- s_rdata  in  DATA_W  slave read data.
- owner  out  1  current/last owner index.
- busy  out  1  high while any master owns the bus.
- err  out  1  sticky: s_rvalid received with no outstanding read.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, cnt=0, served=0, last=1, err=0.
  - All outputs 0: s_valid, s_addr, s_wdata, s_wstrb, mK_ready, mK_rvalid, owner, busy.
  - Reset mid-transaction discards all outstanding responses.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - s_valid=0, mK_ready=0, s_addr/s_wdata/s_wstrb=0.
  - If exactly one mK_valid: go to OWNk.
  - If both are valid: go to OWN of the master != last.
  - Always 1 cycle arbitration latency; no request is forwarded in IDLE.
- OWNk:
  - Combinational pass-through: s_valid = mk_valid & (cnt<MAX_OUTST); s_addr/s_wdata/s_wstrb = mk fields; mk_ready = s_ready & (cnt<MAX_OUTST).
  - The other master's ready = 0.
  - owner=k, busy=1.
- Accept = s_valid & s_ready. An accept sets served=1.
- Read accept (accept & s_wstrb==0): cnt+1.
- s_rvalid with cnt>0: cnt-1, routed to the owner's rvalid.
- Read accept and s_rvalid in the same cycle: cnt unchanged.
- Counter width is clog2(MAX_OUTST+1); cnt never exceeds MAX_OUTST. At cnt==MAX_OUTST, requests stall (s_valid=0) until a response arrives.
- mK_rdata = s_rdata for both masters; only the owner's rvalid is asserted. Non-owner rvalid is always 0.
- s_rvalid with cnt==0: response dropped, no rvalid to either master, err set to 1 until reset.
- Release OWNk → IDLE (next cycle) when cnt==0 (counting the decrement this cycle), and either:
  - mk_valid==0, or
  - served==1 and the other master is valid.
- On release: last=k, served=0.
- Writes never hold ownership (no response expected). Response latency from the slave is unbounded.

Test Plan:
- Single master 0 read at addr 0x100, slave ready next cycle, rvalid with rdata 0xDEADBEEF 2 cycles later → one arbitration cycle, m0_ready once, m0_rvalid with 0xDEADBEEF, m1_rvalid=0, then return to IDLE, busy=0.
- Both masters request a read simultaneously after reset → master 0 granted first, then master 1 granted; masters alternate on repeated simultaneous requests; no response is misrouted.
- Master 1 issues 5 back-to-back reads, slave always ready, responses delayed 8 cycles, MAX_OUTST=4 → exactly 4 accepts, then s_valid=0 until the first rvalid, then the 5th is accepted; the owner is held until cnt=0.
- Master 0 write (wstrb=0xF, data 0x12345678) while master 1 is waiting → after the write accept with m1 valid, release to IDLE, then OWN1; no rvalid for the write.
- s_rvalid pulse with cnt=0 → no mK_rvalid, err=1 and it stays 1.
- rst_n asserted low with 2 reads outstanding → all outputs 0 immediately, cnt=0; after release, a fresh request is arbitrated normally with master 0 as tie winner.
